// File: rtl/adder_arbiter.sv
// Shares one external 4-bit adder between two requesters. Each W-bit operation
// runs as NIB nibble passes, with the carry chained from one pass to the next.
module adder_arbiter #(
    parameter int NIB = 2,
    localparam int W  = 4 * NIB
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         req0_i,
    input  logic         req1_i,
    input  logic [W-1:0] opa0_i,
    input  logic [W-1:0] opb0_i,
    input  logic [W-1:0] opa1_i,
    input  logic [W-1:0] opb1_i,
    input  logic [1:0]   mode0_i,
    input  logic [1:0]   mode1_i,
    input  logic         cin0_i,
    input  logic         cin1_i,
    output logic         ack0_o,
    output logic         ack1_o,
    output logic         done0_o,
    output logic         done1_o,
    output logic [W-1:0] result_o,
    output logic         result_cout_o,
    output logic [3:0]   alu_a_o,
    output logic [3:0]   alu_b_o,
    output logic         alu_s0_o,
    output logic         alu_s1_o,
    output logic         alu_cin_o,
    input  logic [3:0]   alu_s_i,
    input  logic         alu_cout_i
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q;
    logic [1:0]   pass_q;
    logic [W-1:0] opa_q;
    logic [W-1:0] opb_q;
    logic [W-1:0] result_q;
    logic [W-1:0] result_d;
    logic [1:0]   mode_q;
    logic         cin_q;
    logic         id_q;
    logic         carry_q;
    logic         last_q;
    logic         cout_q;
    logic         ack0_q;
    logic         ack1_q;
    logic         done0_q;
    logic         done1_q;
    logic         win_id;
    logic         last_pass;

    // On a tie the requester not granted last wins; last_q resets to 1 so 0 wins first.
    assign win_id    = (req0_i && req1_i) ? ~last_q : req1_i;
    assign last_pass = (pass_q == 2'(NIB - 1));

    assign ack0_o        = ack0_q;
    assign ack1_o        = ack1_q;
    assign done0_o       = done0_q;
    assign done1_o       = done1_q;
    assign result_o      = result_q;
    assign result_cout_o = cout_q;

    // Adder drive is decoded from registered state only; idle drives zeros.
    always_comb begin
        alu_a_o   = 4'd0;
        alu_b_o   = 4'd0;
        alu_s0_o  = 1'b0;
        alu_s1_o  = 1'b0;
        alu_cin_o = 1'b0;
        result_d  = result_q;
        if (state_q == RUN) begin
            alu_s0_o  = mode_q[0];
            alu_s1_o  = mode_q[1];
            alu_cin_o = (pass_q == 2'd0) ? cin_q : carry_q;
            for (int i = 0; i < NIB; i++) begin
                if (pass_q == 2'(i)) begin
                    alu_a_o              = opa_q[4*i +: 4];
                    alu_b_o              = opb_q[4*i +: 4];
                    result_d[4*i +: 4]   = alu_s_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            pass_q   <= 2'd0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            mode_q   <= 2'd0;
            cin_q    <= 1'b0;
            id_q     <= 1'b0;
            carry_q  <= 1'b0;
            last_q   <= 1'b1;
            cout_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        id_q    <= win_id;
                        opa_q   <= win_id ? opa1_i  : opa0_i;
                        opb_q   <= win_id ? opb1_i  : opb0_i;
                        mode_q  <= win_id ? mode1_i : mode0_i;
                        cin_q   <= win_id ? cin1_i  : cin0_i;
                        pass_q  <= 2'd0;
                        ack0_q  <= ~win_id;
                        ack1_q  <= win_id;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= alu_cout_i;
                    pass_q   <= pass_q + 2'd1;
                    if (last_pass) begin
                        cout_q  <= alu_cout_i;
                        done0_q <= ~id_q;
                        done1_q <= id_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    last_q  <= id_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a table of single operations on a NIB=2
// instance plus hand sequences for ties, reset, ignored requests and NIB=1.
module tb_adder_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0, req1;
    logic [7:0] opa0, opb0, opa1, opb1;
    logic [1:0] mode0, mode1;
    logic       cin0, cin1;
    logic       ack0, ack1, done0, done1;
    logic [7:0] result;
    logic       rcout;
    logic [3:0] alu_a, alu_b, alu_s, bsel;
    logic       alu_s0, alu_s1, alu_cin, alu_cout;

    // Adder model: s0 selects a + ~b + cin, otherwise a + b + cin.
    assign bsel = alu_s0 ? ~alu_b : alu_b;
    assign {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, bsel} + {4'd0, alu_cin};

    adder_arbiter #(.NIB(2)) dut (
        .clk_i(clk), .reset_i(rst),
        .req0_i(req0), .req1_i(req1),
        .opa0_i(opa0), .opb0_i(opb0), .opa1_i(opa1), .opb1_i(opb1),
        .mode0_i(mode0), .mode1_i(mode1), .cin0_i(cin0), .cin1_i(cin1),
        .ack0_o(ack0), .ack1_o(ack1), .done0_o(done0), .done1_o(done1),
        .result_o(result), .result_cout_o(rcout),
        .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_s0_o(alu_s0), .alu_s1_o(alu_s1), .alu_cin_o(alu_cin),
        .alu_s_i(alu_s), .alu_cout_i(alu_cout)
    );

    logic       n_req0, n_req1;
    logic [3:0] n_opa0, n_opb0, n_opa1, n_opb1;
    logic [1:0] n_mode0, n_mode1;
    logic       n_cin0, n_cin1;
    logic       n_ack0, n_ack1, n_done0, n_done1;
    logic [3:0] n_result;
    logic       n_rcout;
    logic [3:0] n_alu_a, n_alu_b, n_alu_s;
    logic       n_alu_s0, n_alu_s1, n_alu_cin, n_alu_cout;

    assign {n_alu_cout, n_alu_s} = {1'b0, n_alu_a} + {1'b0, n_alu_b} + {4'd0, n_alu_cin};

    adder_arbiter #(.NIB(1)) dut1 (
        .clk_i(clk), .reset_i(rst),
        .req0_i(n_req0), .req1_i(n_req1),
        .opa0_i(n_opa0), .opb0_i(n_opb0), .opa1_i(n_opa1), .opb1_i(n_opb1),
        .mode0_i(n_mode0), .mode1_i(n_mode1), .cin0_i(n_cin0), .cin1_i(n_cin1),
        .ack0_o(n_ack0), .ack1_o(n_ack1), .done0_o(n_done0), .done1_o(n_done1),
        .result_o(n_result), .result_cout_o(n_rcout),
        .alu_a_o(n_alu_a), .alu_b_o(n_alu_b),
        .alu_s0_o(n_alu_s0), .alu_s1_o(n_alu_s1), .alu_cin_o(n_alu_cin),
        .alu_s_i(n_alu_s), .alu_cout_i(n_alu_cout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       id;
        logic [7:0] a, b;
        logic [1:0] mode;
        logic       cin;
        logic [7:0] res;
        logic       cout;
        logic       cin1;   // carry expected on pass 1
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int n;
        logic got;
        @(negedge clk);
        if (v.id) begin
            req1 = 1'b1; opa1 = v.a; opb1 = v.b; mode1 = v.mode; cin1 = v.cin;
        end else begin
            req0 = 1'b1; opa0 = v.a; opb0 = v.b; mode0 = v.mode; cin0 = v.cin;
        end
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            n++;
            if (v.id ? ack1 : ack0) got = 1'b1;
        end
        chk("ack_latency", n, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        chk("ack_other", v.id ? ack0 : ack1, 0);
        chk("pass0_a", alu_a, v.a[3:0]);
        chk("pass0_b", alu_b, v.b[3:0]);
        chk("pass0_mode", {alu_s1, alu_s0}, v.mode);
        chk("pass0_cin", alu_cin, v.cin);
        @(negedge clk);
        chk("pass1_a", alu_a, v.a[7:4]);
        chk("pass1_cin", alu_cin, v.cin1);
        @(negedge clk);
        chk("done_own", v.id ? done1 : done0, 1);
        chk("done_other", v.id ? done0 : done1, 0);
        chk("result", result, v.res);
        chk("result_cout", rcout, v.cout);
        $display("op id=%0d a=%h b=%h mode=%b cin=%0d -> result=%h cout=%0d",
                 v.id, v.a, v.b, v.mode, v.cin, result, rcout);
    endtask

    initial begin
        int cyc, last_done, nack, ndone, n;
        logic [3:0] ord;
        logic saw_ack1, saw_done1, saw_done0, got;
        logic [7:0] res0;

        vecs[0] = '{1'b0, 8'h3C, 8'h0F, 2'b00, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'h0F, 8'h01, 2'b00, 1'b0, 8'h10, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'hFF, 8'h01, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 8'h00, 2'b00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h50, 8'h20, 2'b01, 1'b1, 8'h30, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h12, 8'h34, 2'b10, 1'b0, 8'h46, 1'b0, 1'b0};

        rst = 1'b1;
        req0 = 0; req1 = 0; opa0 = 0; opb0 = 0; opa1 = 0; opb1 = 0;
        mode0 = 0; mode1 = 0; cin0 = 0; cin1 = 0;
        n_req0 = 0; n_req1 = 0; n_opa0 = 0; n_opb0 = 0; n_opa1 = 0; n_opb1 = 0;
        n_mode0 = 0; n_mode1 = 0; n_cin0 = 0; n_cin1 = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", {ack1, ack0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", rcout, 0);
        chk("rst_alu", {alu_a, alu_b, alu_s1, alu_s0, alu_cin}, 0);

        // Both requesters held from reset release: 0,1,0,1 with 4-cycle done spacing
        req0 = 1; opa0 = 8'h11; opb0 = 8'h22;
        req1 = 1; opa1 = 8'h0A; opb1 = 8'h07;
        rst = 0;
        nack = 0; ndone = 0; ord = 4'd0; last_done = 0;
        for (cyc = 1; cyc <= 30 && ndone < 4; cyc++) begin
            @(negedge clk);
            if ((ack0 || ack1) && nack < 4) begin
                ord[nack] = ack1;
                nack++;
                if (nack == 4) begin req0 = 0; req1 = 0; end
            end
            if (done0 || done1) begin
                chk("tie_result", result, done1 ? 8'h11 : 8'h33);
                if (ndone > 0) chk("tie_done_spacing", cyc - last_done, 4);
                $display("tie op id=%0d result=%h at cycle %0d", done1, result, cyc);
                last_done = cyc;
                ndone++;
            end
        end
        chk("tie_done_count", ndone, 4);
        chk("tie_grant_order", ord, 4'b1010);

        // Table-driven single operations
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // req1 pulsed during RUN is ignored; req0 operands changed after ack
        @(negedge clk);
        req0 = 1; opa0 = 8'h21; opb0 = 8'h13; mode0 = 0; cin0 = 0;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack0) got = 1;
        end
        chk("pulse_ack0_seen", got, 1);
        req0 = 0; opa0 = 8'hFF; opb0 = 8'hFF;
        req1 = 1; opa1 = 8'h55; opb1 = 8'h55;
        @(negedge clk);
        req1 = 0;
        saw_ack1 = 0; saw_done1 = 0; saw_done0 = 0; res0 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack1) saw_ack1 = 1;
            if (done1) saw_done1 = 1;
            if (done0) begin saw_done0 = 1; res0 = result; end
        end
        chk("pulse_no_ack1", saw_ack1, 0);
        chk("pulse_no_done1", saw_done1, 0);
        chk("pulse_done0", saw_done0, 1);
        chk("latched_operands", res0, 8'h34);
        $display("pulse op id=0 result=%h, req1 acked=%0d", res0, saw_ack1);

        // Reset during pass 1, then held req0 re-granted
        @(negedge clk);
        req0 = 1; opa0 = 8'h3C; opb0 = 8'h0F; mode0 = 0; cin0 = 0;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack0) got = 1;
        end
        chk("rstmid_ack0", got, 1);
        @(negedge clk);
        chk("rstmid_pass1_a", alu_a, 4'h3);
        rst = 1;
        #1;
        chk("rstmid_result", result, 0);
        chk("rstmid_alu", {alu_a, alu_b, alu_cin}, 0);
        chk("rstmid_pulses", {ack0, ack1, done0, done1}, 0);
        @(negedge clk);
        rst = 0;
        got = 0; saw_done0 = 0; n = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            n++;
            if (done0) saw_done0 = 1;
            if (ack0) got = 1;
        end
        chk("rstmid_regrant_latency", n, 1);
        chk("rstmid_no_done", saw_done0, 0);
        req0 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_done0", done0, 1);
        chk("rstmid_final_result", result, 8'h4B);
        $display("reset-mid op id=0 result=%h", result);

        // NIB=1 instance: 9 + 8
        @(negedge clk);
        n_req0 = 1; n_opa0 = 4'h9; n_opb0 = 4'h8; n_cin0 = 0;
        got = 0; n = 0; cyc = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            n++;
            if (n_ack0) begin cyc = n; n_req0 = 0; end
            if (n_done0) got = 1;
        end
        chk("nib1_ack_cycle", cyc, 1);
        chk("nib1_done_cycle", n, 2);
        chk("nib1_result", n_result, 4'h1);
        chk("nib1_cout", n_rcout, 1);
        $display("nib1 op id=0 a=9 b=8 -> result=%h cout=%0d", n_result, n_rcout);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
